// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: checks the ID-stage static prediction against the EX outcome and issues a one-cycle redirect plus flushes.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_branch_b,
    input  logic             id_jal,
    input  logic             id_jalr,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             id_pred_taken,
    input  logic [XLEN-1:0]  id_pred_pc,
    input  logic             ex_stall,
    input  logic             ex_cond,
    input  logic [XLEN-1:0]  ex_target,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    state_t            state;

    logic              rec_valid;
    logic              rec_b;
    logic              rec_jal;
    logic              rec_jalr;
    logic [XLEN-1:0]   rec_pc;
    logic              rec_pred_taken;
    logic [XLEN-1:0]   rec_pred_pc;

    logic              resolve_c;
    logic              actual_taken_c;
    logic [XLEN-1:0]   actual_pc_c;
    logic              mispredict_c;
    logic              squash_c;
    logic              id_ctrl_c;

    // Outcome of the instruction held in EX
    always_comb begin
        resolve_c      = rec_valid & ~ex_stall;
        actual_taken_c = rec_jal | rec_jalr | (rec_b & ex_cond);
        actual_pc_c    = actual_taken_c ? ex_target : (rec_pc + XLEN'(4));
        mispredict_c   = resolve_c & (state == S_IDLE) &
                         ((actual_taken_c != rec_pred_taken) |
                          (actual_taken_c & rec_pred_taken & (rec_pred_pc != ex_target)));
        squash_c       = mispredict_c | (state == S_REDIRECT);
        id_ctrl_c      = id_valid & (id_branch_b | id_jal | id_jalr);
    end

    // Prediction record of the instruction entering EX; wrong-path loads are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_valid      <= 1'b0;
            rec_b          <= 1'b0;
            rec_jal        <= 1'b0;
            rec_jalr       <= 1'b0;
            rec_pc         <= '0;
            rec_pred_taken <= 1'b0;
            rec_pred_pc    <= '0;
        end else if (!ex_stall) begin
            rec_valid      <= id_ctrl_c & ~squash_c;
            rec_b          <= id_branch_b;
            rec_jal        <= id_jal;
            rec_jalr       <= id_jalr;
            rec_pc         <= id_pc;
            rec_pred_taken <= id_pred_taken;
            rec_pred_pc    <= id_pred_pc;
        end
    end

    // Redirect FSM with registered strobes; the REDIRECT cycle ignores ex_stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mispredict_c) begin
                        state          <= S_REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= actual_pc_c;
                        flush_if_id    <= 1'b1;
                        flush_id_ex    <= 1'b1;
                    end
                end
                S_REDIRECT: begin
                    state          <= S_IDLE;
                    redirect_valid <= 1'b0;
                    flush_if_id    <= 1'b0;
                    flush_id_ex    <= 1'b0;
                end
                default: begin
                    state          <= S_IDLE;
                    redirect_valid <= 1'b0;
                    flush_if_id    <= 1'b0;
                    flush_id_ex    <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Saturating resolution / mispredict counters
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (resolve_c && (branch_cnt != {CNT_W{1'b1}})) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispredict_c && (mispredict_cnt != {CNT_W{1'b1}})) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign branch_cnt     = '0;
    assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random traffic against a behavioural model.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;
    localparam longint      CMAX  = (64'd1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic             id_branch_b;
    logic             id_jal;
    logic             id_jalr;
    logic [XLEN-1:0]  id_pc;
    logic             id_pred_taken;
    logic [XLEN-1:0]  id_pred_pc;
    logic             ex_stall;
    logic             ex_cond;
    logic [XLEN-1:0]  ex_target;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_branch_b    (id_branch_b),
        .id_jal         (id_jal),
        .id_jalr        (id_jalr),
        .id_pc          (id_pc),
        .id_pred_taken  (id_pred_taken),
        .id_pred_pc     (id_pred_pc),
        .ex_stall       (ex_stall),
        .ex_cond        (ex_cond),
        .ex_target      (ex_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the control-transfer instruction sitting in EX
    typedef struct {
        bit          v;
        int          kind;   // 1 = B-type, 2 = jal, 3 = jalr
        logic [31:0] pc;
        bit          pt;
        logic [31:0] ppc;
    } ex_inst_t;

    ex_inst_t    m_ex;
    bit          m_redir;
    logic [31:0] m_rpc;
    longint      m_bcnt;
    longint      m_mcnt;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive ID/EX inputs, advance the model, compare all outputs
    task automatic step(input bit r, input bit v, input int kind, input logic [31:0] pc,
                        input bit pt, input logic [31:0] ppc, input bit st,
                        input bit cond, input logic [31:0] tgt);
        bit          res;
        bit          taken;
        bit          mis;
        bit          was_redir;
        logic [31:0] nxt;
        rst           = r;
        id_valid      = v;
        id_branch_b   = (kind == 1);
        id_jal        = (kind == 2);
        id_jalr       = (kind == 3);
        id_pc         = pc;
        id_pred_taken = pt;
        id_pred_pc    = ppc;
        ex_stall      = st;
        ex_cond       = cond;
        ex_target     = tgt;

        was_redir = m_redir;
        res   = m_ex.v && !st;
        taken = (m_ex.kind == 2) || (m_ex.kind == 3) || ((m_ex.kind == 1) && cond);
        nxt   = taken ? tgt : m_ex.pc + 32'd4;
        mis   = res && !was_redir &&
                ((taken != m_ex.pt) || (taken && m_ex.ppc != tgt));

        @(posedge clk);
        #1;

        if (r) begin
            m_ex    = '{v: 1'b0, kind: 0, pc: 32'h0, pt: 1'b0, ppc: 32'h0};
            m_redir = 1'b0;
            m_rpc   = 32'h0;
            m_bcnt  = 0;
            m_mcnt  = 0;
        end else begin
            if (res && m_bcnt < CMAX) m_bcnt++;
            if (mis && m_mcnt < CMAX) m_mcnt++;
            if (!st) begin
                m_ex.v    = v && (kind != 0) && !mis && !was_redir;
                m_ex.kind = kind;
                m_ex.pc   = pc;
                m_ex.pt   = pt;
                m_ex.ppc  = ppc;
            end
            if (was_redir) m_redir = 1'b0;
            else if (mis) begin
                m_redir = 1'b1;
                m_rpc   = nxt;
            end
        end

        check("redirect_valid", 64'(redirect_valid), 64'(m_redir));
        check("flush_if_id",    64'(flush_if_id),    64'(m_redir));
        check("flush_id_ex",    64'(flush_id_ex),    64'(m_redir));
        check("redirect_pc",    64'(redirect_pc),    64'(m_rpc));
`ifdef BRU_PERF_CNT_EN
        check("branch_cnt",     64'(branch_cnt),     64'(m_bcnt));
        check("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mcnt));
`else
        check("branch_cnt_tie", 64'(branch_cnt),     64'd0);
        check("mispred_cnt_tie", 64'(mispredict_cnt), 64'd0);
`endif
    endtask

    task automatic idle(input bit cond, input logic [31:0] tgt);
        step(1'b0, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0, cond, tgt);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_ex     = '{v: 1'b0, kind: 0, pc: 32'h0, pt: 1'b0, ppc: 32'h0};
        m_redir  = 1'b0;
        m_rpc    = 32'h0;
        m_bcnt   = 0;
        m_mcnt   = 0;

        step(1'b1, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("reset_rv",  64'(redirect_valid), 64'd0);
        check("reset_rpc", 64'(redirect_pc),    64'd0);

        // B-type backward, correctly predicted
        step(1'b0, 1'b1, 1, 32'h100, 1'b1, 32'hF0, 1'b0, 1'b0, 32'h0);
        idle(1'b1, 32'hF0);
        check("bwd_no_redirect", 64'(redirect_valid), 64'd0);
`ifdef BRU_PERF_CNT_EN
        check("bwd_bcnt", 64'(branch_cnt),     64'd1);
        check("bwd_mcnt", 64'(mispredict_cnt), 64'd0);
`endif

        // B-type forward, predicted not-taken; ID instructions in resolve/redirect cycles are wrong-path
        step(1'b0, 1'b1, 1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1, 32'h500, 1'b1, 32'h600, 1'b0, 1'b1, 32'h240);
        check("fwd_rv",  64'(redirect_valid), 64'd1);
        check("fwd_rpc", 64'(redirect_pc),    64'h240);
        check("fwd_fl",  64'(flush_if_id & flush_id_ex), 64'd1);
        step(1'b0, 1'b1, 3, 32'h700, 1'b0, 32'h0, 1'b0, 1'b1, 32'h999);
        check("fwd_one_cycle", 64'(redirect_valid), 64'd0);
        idle(1'b1, 32'h123);
        check("fwd_wrong_path", 64'(redirect_valid), 64'd0);

        // Loop exit and PC wrap
        step(1'b0, 1'b1, 1, 32'h300, 1'b1, 32'h2C0, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 32'h2C0);
        check("exit_rpc", 64'(redirect_pc), 64'h304);
        idle(1'b0, 32'h0);
        step(1'b0, 1'b1, 1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 32'h10);
        check("wrap_rpc", 64'(redirect_pc), 64'h0);
        idle(1'b0, 32'h0);

        // jalr wrong target, dependent jalr, jal correct
        step(1'b0, 1'b1, 3, 32'h80, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 32'h1004);
        check("jalr_rpc", 64'(redirect_pc), 64'h1004);
        idle(1'b0, 32'h0);
        step(1'b0, 1'b1, 3, 32'h90, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 32'h800);
        check("jalr_dep_rpc", 64'(redirect_pc), 64'h800);
        idle(1'b0, 32'h0);
        step(1'b0, 1'b1, 2, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
        idle(1'b0, 32'h80);
        check("jal_ok", 64'(redirect_valid), 64'd0);
        check("jal_rpc_hold", 64'(redirect_pc), 64'h800);

        // Stall with a mispredicting branch in EX
        step(1'b0, 1'b1, 1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2, 32'h900 + 32'(i * 4), 1'b1, 32'hA00, 1'b1, 1'b1, 32'h480);
            check("stall_no_rv", 64'(redirect_valid), 64'd0);
        end
        idle(1'b1, 32'h480);
        check("stall_rv",  64'(redirect_valid), 64'd1);
        check("stall_rpc", 64'(redirect_pc),    64'h480);
        idle(1'b0, 32'h0);

        // Reset in the REDIRECT cycle
        step(1'b0, 1'b1, 1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(1'b1, 32'h680);
        check("pre_rst_rv", 64'(redirect_valid), 64'd1);
        step(1'b1, 1'b1, 1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b1, 32'h780);
        check("rst_rv",  64'(redirect_valid), 64'd0);
        check("rst_rpc", 64'(redirect_pc),    64'd0);
        check("rst_fl",  64'(flush_if_id | flush_id_ex), 64'd0);
        check("rst_cnt", 64'(branch_cnt | mispredict_cnt), 64'd0);
        idle(1'b1, 32'h780);
        check("rst_rec_clear", 64'(redirect_valid), 64'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ppc;
            logic [31:0] tgt;
            ppc = {$urandom_range(0, 1023), 2'b00};
            tgt = ($urandom_range(0, 1) == 1) ? ppc : {$urandom_range(0, 1023), 2'b00};
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 1023), 2'b00},
                 $urandom_range(0, 1) == 1,
                 ppc,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
